uart_link_driver: RTL and testbench

//  Host-side driver for the UART loopback top: the initiating end of its send/data_in and rx_done/data_out interface.

---
 rtl/uart_link_driver_if.sv | 44 ++++
 rtl/uart_link_driver.sv | 172 +++++++++++++++++
 tb/tb_uart_link_driver.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_link_driver_if.sv
// ============================================================================
//  Module      : uart_link_driver_if
//  Description : Source, UART-top and result signals of the UART link driver.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_link_driver_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        send;
  logic [7:0]  tx_data;
  logic        tx_active_flag;
  logic        tx_done_flag;
  logic        rx_done_flag;
  logic [7:0]  rx_data;
  logic [2:0]  error_flag;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_err;
  logic        timeout;
  logic [15:0] pass_count;
  logic [15:0] fail_count;
  logic        busy;

  modport master (
    input  in_valid, in_data,
    output in_ready,
    output send, tx_data,
    input  tx_active_flag, tx_done_flag, rx_done_flag, rx_data, error_flag,
    output out_valid, out_data, out_err, timeout, pass_count, fail_count, busy
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready,
    input  send, tx_data,
    output tx_active_flag, tx_done_flag, rx_done_flag, rx_data, error_flag,
    input  out_valid, out_data, out_err, timeout, pass_count, fail_count, busy
  );
endinterface

`default_nettype wire

// File: rtl/uart_link_driver.sv
// ============================================================================
//  Module      : uart_link_driver
//  Description : Buffers bytes, sends one UART loopback frame per byte and
//                reports a pass/fail result per byte with saturating counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_link_driver #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1000000,
  parameter int TO_W       = 20
) (
  input  logic                clock,
  input  logic                reset,
  uart_link_driver_if.master  lnk
);

  localparam int c_addr_w = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEND   = 2'd1,
    S_WAIT   = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [c_addr_w:0]   r_count;
  logic [7:0]          r_exp;
  logic [7:0]          r_rx_cap;
  logic [2:0]          r_err_cap;
  logic                r_tx_seen;
  logic                r_rx_seen;
  logic                r_to;
  logic [TO_W-1:0]     r_timer;
  logic [15:0]         r_pass;
  logic [15:0]         r_fail;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_timer_end;
  logic w_expired;
  logic w_report;
  logic w_bad;

  assign w_full      = (r_count == (c_addr_w+1)'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = lnk.in_valid & ~w_full;
  assign w_pop       = (r_state == S_IDLE) & ~w_empty;
  assign w_timer_end = (r_timer == TO_W'(TIMEOUT - 1));
  assign w_report    = (r_state == S_REPORT);
  assign w_bad       = r_to | (r_rx_cap != r_exp) | (|r_err_cap);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Completion flags arriving in the expiry cycle are deliberately ignored:
  // the timeout wins and the frame is reported as failed.
  always_comb begin
    w_state_nxt = r_state;
    w_expired   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (w_timer_end) begin
          w_expired   = 1'b1;
          w_state_nxt = S_REPORT;
        end else if (lnk.tx_active_flag) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_timer_end) begin
          w_expired   = 1'b1;
          w_state_nxt = S_REPORT;
        end else if ((r_tx_seen | lnk.tx_done_flag) && (r_rx_seen | lnk.rx_done_flag)) begin
          w_state_nxt = S_REPORT;
        end
      end
      S_REPORT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= lnk.in_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_exp     <= '0;
      r_rx_cap  <= '0;
      r_err_cap <= '0;
      r_tx_seen <= 1'b0;
      r_rx_seen <= 1'b0;
      r_to      <= 1'b0;
      r_timer   <= '0;
      r_pass    <= '0;
      r_fail    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_addr_w+1)'(1);
        2'b01:   r_count <= r_count - (c_addr_w+1)'(1);
        default: r_count <= r_count;
      endcase

      if (w_pop) begin
        r_exp     <= r_mem[r_rd_ptr];
        r_rx_cap  <= '0;
        r_err_cap <= '0;
        r_tx_seen <= 1'b0;
        r_rx_seen <= 1'b0;
        r_to      <= 1'b0;
        r_timer   <= '0;
      end else if (r_state == S_SEND || r_state == S_WAIT) begin
        r_timer <= r_timer + TO_W'(1);
      end

      if (r_state == S_WAIT) begin
        if (lnk.tx_done_flag) r_tx_seen <= 1'b1;
        if (lnk.rx_done_flag) begin
          r_rx_seen <= 1'b1;
          r_rx_cap  <= lnk.rx_data;
          r_err_cap <= lnk.error_flag;
        end
      end

      if (w_expired) r_to <= 1'b1;

      if (w_report) begin
        if (w_bad) begin
          if (r_fail != 16'hFFFF) r_fail <= r_fail + 16'd1;
        end else begin
          if (r_pass != 16'hFFFF) r_pass <= r_pass + 16'd1;
        end
      end
    end
  end

  assign lnk.in_ready   = ~w_full;
  assign lnk.send       = (r_state == S_SEND);
  assign lnk.tx_data    = r_exp;
  assign lnk.busy       = (r_state != S_IDLE);
  assign lnk.out_valid  = w_report;
  assign lnk.out_err    = w_report & w_bad;
  assign lnk.timeout    = w_report & r_to;
  assign lnk.out_data   = w_report ? (r_to ? r_exp : r_rx_cap) : 8'h00;
  assign lnk.pass_count = r_pass;
  assign lnk.fail_count = r_fail;

endmodule

`default_nettype wire

// File: tb/tb_uart_link_driver.sv
// ============================================================================
//  Module      : tb_uart_link_driver
//  Description : Directed self-checking bench for uart_link_driver.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_link_driver;
  logic clock;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  logic [7:0] q_data[$];
  logic       q_err[$];

  uart_link_driver_if lif();

  uart_link_driver #(.FIFO_DEPTH(4), .TIMEOUT(100), .TO_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .lnk   (lif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Result collector, sampled on the falling edge.
  always @(negedge clock) begin
    if (lif.out_valid === 1'b1) begin
      q_data.push_back(lif.out_data);
      q_err.push_back(lif.out_err);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    q_data.delete();
    q_err.delete();
  endtask

  task automatic push(input logic [7:0] b);
    int t;
    t = 0;
    while (lif.in_ready !== 1'b1 && t < 500) begin tick(1); t++; end
    lif.in_valid = 1'b1;
    lif.in_data  = b;
    tick(1);
    lif.in_valid = 1'b0;
  endtask

  task automatic pulse_tx();
    lif.tx_done_flag = 1'b1;
    tick(1);
    lif.tx_done_flag = 1'b0;
  endtask

  task automatic pulse_rx(input logic [7:0] r, input logic [2:0] ef);
    lif.rx_done_flag = 1'b1;
    lif.rx_data      = r;
    lif.error_flag   = ef;
    tick(1);
    lif.rx_done_flag = 1'b0;
    lif.error_flag   = 3'b000;
  endtask

  // Acts as the UART top for one frame; order 0 = tx first, 1 = rx first, 2 = same cycle.
  task automatic serve(input bit force_rx, input logic [7:0] rxb, input logic [2:0] ef, input int order);
    int t;
    logic [7:0] r;
    t = 0;
    while (lif.send !== 1'b1 && t < 300) begin tick(1); t++; end
    checks++;
    if (lif.send !== 1'b1) begin
      failures++;
      $display("FAIL serve_send_wait: send=%b required 1", lif.send);
      return;
    end
    r = force_rx ? rxb : lif.tx_data;
    lif.tx_active_flag = 1'b1;
    tick(2);
    case (order)
      0: begin pulse_tx(); tick(1); pulse_rx(r, ef); end
      1: begin pulse_rx(r, ef); tick(1); pulse_tx(); end
      default: begin
        lif.tx_done_flag = 1'b1;
        pulse_rx(r, ef);
        lif.tx_done_flag = 1'b0;
      end
    endcase
    lif.tx_active_flag = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    checks++; if (lif.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b required 1", lif.in_ready); end
    checks++; if (lif.send !== 1'b0) begin failures++; $display("FAIL reset_send: got %b required 0", lif.send); end
    checks++; if (lif.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", lif.busy); end
    checks++; if (lif.out_valid !== 1'b0 || lif.timeout !== 1'b0) begin failures++; $display("FAIL reset_strobes: out_valid=%b timeout=%b required 0 0", lif.out_valid, lif.timeout); end
    checks++; if (lif.tx_data !== 8'h00 || lif.out_data !== 8'h00) begin failures++; $display("FAIL reset_data: tx_data=%h out_data=%h required 00 00", lif.tx_data, lif.out_data); end
    checks++; if (lif.pass_count !== 16'd0 || lif.fail_count !== 16'd0) begin failures++; $display("FAIL reset_counts: pass=%0d fail=%0d required 0 0", lif.pass_count, lif.fail_count); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    push(8'hA5);
    checks++; if (lif.send !== 1'b0) begin failures++; $display("FAIL single_send_early: got %b required 0", lif.send); end
    tick(1);
    checks++; if (lif.send !== 1'b1 || lif.tx_data !== 8'hA5) begin failures++; $display("FAIL single_launch: send=%b tx_data=%h required 1 a5", lif.send, lif.tx_data); end
    serve(1'b0, 8'h00, 3'b000, 0);
    checks++; if (lif.out_valid !== 1'b1) begin failures++; $display("FAIL single_strobe: out_valid=%b required 1", lif.out_valid); end
    tick(3);
    checks++; if (q_data.size() != 1) begin failures++; $display("FAIL single_count: results=%0d required 1", q_data.size()); end
    else if (q_data[0] !== 8'hA5 || q_err[0] !== 1'b0) begin failures++; $display("FAIL single_result: data=%h err=%b required a5 0", q_data[0], q_err[0]); end
    checks++; if (lif.pass_count !== 16'd1 || lif.fail_count !== 16'd0) begin failures++; $display("FAIL single_counts: pass=%0d fail=%0d required 1 0", lif.pass_count, lif.fail_count); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [5];
    b[0] = 8'h01; b[1] = 8'h82; b[2] = 8'h43; b[3] = 8'hC4; b[4] = 8'h25;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      lif.in_valid = 1'b1;
      lif.in_data  = b[i];
      tick(1);
    end
    checks++; if (lif.in_ready !== 1'b0) begin failures++; $display("FAIL b2b_full: in_ready=%b required 0", lif.in_ready); end
    lif.in_data = 8'h77;
    tick(1);
    lif.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) serve(1'b0, 8'h00, 3'b000, 0);
    tick(6);
    checks++; if (q_data.size() != 5) begin failures++; $display("FAIL b2b_count: results=%0d required 5", q_data.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (q_data[i] !== b[i] || q_err[i] !== 1'b0) begin failures++; $display("FAIL b2b_result%0d: data=%h err=%b required %h 0", i, q_data[i], q_err[i], b[i]); end
      end
    end
    checks++; if (lif.pass_count !== 16'd5 || lif.busy !== 1'b0 || lif.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_final: pass=%0d busy=%b in_ready=%b required 5 0 1", lif.pass_count, lif.busy, lif.in_ready); end
  endtask

  task automatic test_mismatch();
    do_reset();
    push(8'h3C);
    serve(1'b1, 8'h00, 3'b000, 0);
    checks++; if (lif.out_err !== 1'b1 || lif.out_data !== 8'h00) begin failures++; $display("FAIL mismatch_result: err=%b data=%h required 1 00", lif.out_err, lif.out_data); end
    tick(1);
    checks++; if (lif.fail_count !== 16'd1 || lif.pass_count !== 16'd0) begin failures++; $display("FAIL mismatch_counts: pass=%0d fail=%0d required 0 1", lif.pass_count, lif.fail_count); end
    push(8'h5A);
    serve(1'b1, 8'h5A, 3'b100, 1);
    checks++; if (lif.out_err !== 1'b1 || lif.out_data !== 8'h5A) begin failures++; $display("FAIL errflag_result: err=%b data=%h required 1 5a", lif.out_err, lif.out_data); end
    tick(1);
    checks++; if (lif.fail_count !== 16'd2 || lif.pass_count !== 16'd0) begin failures++; $display("FAIL errflag_counts: pass=%0d fail=%0d required 0 2", lif.pass_count, lif.fail_count); end
  endtask

  task automatic test_timeout();
    int c;
    do_reset();
    push(8'h42);
    tick(1);
    lif.tx_active_flag = 1'b1;
    c = 0;
    while (lif.timeout !== 1'b1 && c < 150) begin tick(1); c++; end
    checks++; if (c != 100) begin failures++; $display("FAIL timeout_latency: cycles=%0d required 100", c); end
    checks++; if (lif.out_valid !== 1'b1 || lif.out_err !== 1'b1 || lif.out_data !== 8'h42 || lif.send !== 1'b0) begin failures++; $display("FAIL timeout_result: valid=%b err=%b data=%h send=%b required 1 1 42 0", lif.out_valid, lif.out_err, lif.out_data, lif.send); end
    lif.tx_active_flag = 1'b0;
    tick(1);
    checks++; if (lif.timeout !== 1'b0 || lif.fail_count !== 16'd1 || lif.pass_count !== 16'd0) begin failures++; $display("FAIL timeout_counts: timeout=%b pass=%0d fail=%0d required 0 0 1", lif.timeout, lif.pass_count, lif.fail_count); end
    // Completions landing exactly in the expiry cycle.
    push(8'h43);
    tick(1);
    lif.tx_active_flag = 1'b1;
    tick(99);
    lif.tx_done_flag = 1'b1;
    lif.rx_done_flag = 1'b1;
    lif.rx_data      = 8'h43;
    tick(1);
    lif.tx_done_flag = 1'b0;
    lif.rx_done_flag = 1'b0;
    lif.tx_active_flag = 1'b0;
    checks++; if (lif.timeout !== 1'b1 || lif.out_err !== 1'b1) begin failures++; $display("FAIL timeout_race: timeout=%b err=%b required 1 1", lif.timeout, lif.out_err); end
    tick(3);
    checks++; if (lif.fail_count !== 16'd2 || q_data.size() != 2) begin failures++; $display("FAIL timeout_race_counts: fail=%0d results=%0d required 2 2", lif.fail_count, q_data.size()); end
  endtask

  task automatic test_order();
    do_reset();
    lif.tx_done_flag = 1'b1;
    lif.rx_done_flag = 1'b1;
    lif.rx_data      = 8'hFF;
    tick(1);
    lif.tx_done_flag = 1'b0;
    lif.rx_done_flag = 1'b0;
    push(8'h11);
    push(8'h22);
    serve(1'b0, 8'h00, 3'b000, 1);
    serve(1'b0, 8'h00, 3'b000, 2);
    tick(4);
    checks++; if (q_data.size() != 2) begin failures++; $display("FAIL order_count: results=%0d required 2", q_data.size()); end
    else if (q_data[0] !== 8'h11 || q_data[1] !== 8'h22 || q_err[0] !== 1'b0 || q_err[1] !== 1'b0) begin failures++; $display("FAIL order_result: data=%h,%h err=%b,%b required 11,22 0,0", q_data[0], q_data[1], q_err[0], q_err[1]); end
    checks++; if (lif.pass_count !== 16'd2 || lif.fail_count !== 16'd0) begin failures++; $display("FAIL order_counts: pass=%0d fail=%0d required 2 0", lif.pass_count, lif.fail_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(8'h66);
    lif.in_valid = 1'b1;
    lif.in_data  = 8'h67;
    tick(1);
    lif.in_valid = 1'b0;
    lif.tx_active_flag = 1'b1;
    tick(1);
    pulse_tx();
    reset = 1'b1;
    tick(1);
    checks++; if (lif.send !== 1'b0 || lif.busy !== 1'b0 || lif.out_valid !== 1'b0 || lif.in_ready !== 1'b1) begin failures++; $display("FAIL midreset_state: send=%b busy=%b valid=%b in_ready=%b required 0 0 0 1", lif.send, lif.busy, lif.out_valid, lif.in_ready); end
    reset = 1'b0;
    lif.tx_active_flag = 1'b0;
    tick(5);
    checks++; if (lif.busy !== 1'b0 || q_data.size() != 0 || lif.pass_count !== 16'd0 || lif.fail_count !== 16'd0) begin failures++; $display("FAIL midreset_empty: busy=%b results=%0d pass=%0d fail=%0d required 0 0 0 0", lif.busy, q_data.size(), lif.pass_count, lif.fail_count); end
    push(8'h99);
    serve(1'b0, 8'h00, 3'b000, 0);
    tick(2);
    checks++; if (q_data.size() != 1 || lif.pass_count !== 16'd1) begin failures++; $display("FAIL midreset_resume: results=%0d pass=%0d required 1 1", q_data.size(), lif.pass_count); end
    else if (q_data[0] !== 8'h99) begin failures++; $display("FAIL midreset_data: data=%h required 99", q_data[0]); end
  endtask

  initial begin
    reset              = 1'b1;
    lif.in_valid       = 1'b0;
    lif.in_data        = 8'h00;
    lif.tx_active_flag = 1'b0;
    lif.tx_done_flag   = 1'b0;
    lif.rx_done_flag   = 1'b0;
    lif.rx_data        = 8'h00;
    lif.error_flag     = 3'b000;
    test_reset();
    test_single();
    test_back_to_back();
    test_mismatch();
    test_timeout();
    test_order();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
